// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq_if
// Description : Request/result bundle between a binary source and the
//               sequential binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_seq_if;
   logic        start;
   logic [15:0] bin;
   logic        busy;
   logic        done;
   logic [15:0] bcd;
   logic        ovf;

   // Source side: issues requests, observes results
   modport master (
      output start,
      output bin,
      input  busy,
      input  done,
      input  bcd,
      input  ovf
   );

   // Converter side
   modport slave (
      input  start,
      input  bin,
      output busy,
      output done,
      output bcd,
      output ovf
   );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : 16-bit unsigned binary to 4-digit packed BCD, one bit per
//               clock (shift-and-add-3). Inputs above 9999 saturate to 9999
//               and raise ovf. Results update only when a conversion ends,
//               so a downstream display never sees partial digits.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
   parameter bit AUTO = 1'b0
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   bin_to_bcd_seq_if.slave bus
);

   localparam logic [15:0] c_BIN_MAX  = 16'd9999;
   localparam logic [4:0]  c_LAST_CNT = 5'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [15:0] r_bin_sr;
   logic [15:0] r_scratch;
   logic [4:0]  r_cnt;
   logic        r_ovf_next;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_bcd;
   logic        r_ovf;

   logic        w_accept;
   logic        w_last;
   logic        w_bin_ovf;
   logic [15:0] w_bin_clamp;
   logic [15:0] w_scratch_adj;
   logic [15:0] w_scratch_shf;
   logic [15:0] w_bin_shf;

   assign w_accept    = (r_state == ST_IDLE) && (bus.start || AUTO);
   assign w_last      = (r_cnt == c_LAST_CNT);
   assign w_bin_ovf   = (bus.bin > c_BIN_MAX);
   assign w_bin_clamp = w_bin_ovf ? c_BIN_MAX : bus.bin;

   // Add-3 correction on every digit that would reach 10+ after doubling
   always_comb begin
      w_scratch_adj = r_scratch;
      for (int i = 0; i < 4; i++) begin
         if (r_scratch[i*4 +: 4] >= 4'd5) begin
            w_scratch_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
         end
      end
   end

   // One left shift of the {scratch, binary} pair
   assign w_scratch_shf = {w_scratch_adj[14:0], r_bin_sr[15]};
   assign w_bin_shf     = {r_bin_sr[14:0], 1'b0};

   // Next-state selection
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_next = ST_SHIFT;
         ST_SHIFT: if (w_last)   w_state_next = ST_DONE;
         ST_DONE:                w_state_next = ST_IDLE;
         default:                w_state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath and registered status/result outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bin_sr   <= 16'h0000;
         r_scratch  <= 16'h0000;
         r_cnt      <= 5'd0;
         r_ovf_next <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= 16'h0000;
         r_ovf      <= 1'b0;
      end else begin
         r_busy <= (w_state_next != ST_IDLE);
         r_done <= (w_state_next == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_bin_sr   <= w_bin_clamp;
                  r_ovf_next <= w_bin_ovf;
                  r_scratch  <= 16'h0000;
                  r_cnt      <= 5'd0;
               end
            end
            ST_SHIFT: begin
               r_scratch <= w_scratch_shf;
               r_bin_sr  <= w_bin_shf;
               r_cnt     <= r_cnt + 5'd1;
               // Publish on the final shift so digits are visible in DONE
               if (w_last) begin
                  r_bcd <= w_scratch_shf;
                  r_ovf <= r_ovf_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.bcd  = r_bcd;
   assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq. One instance with
//               AUTO=0 driven by directed and random requests, one with
//               AUTO=1 fed a sweeping operand; both compared every cycle
//               against a countdown/decimal-arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

   logic clk;
   logic rst_n;
   logic chk_en;
   int   checks;
   int   errors;

   bin_to_bcd_seq_if if0 ();
   bin_to_bcd_seq_if if1 ();

   bin_to_bcd_seq #(.AUTO(1'b0)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   bin_to_bcd_seq #(.AUTO(1'b1)) u_auto (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal reference: clamp to 9999 and split into digits
   function automatic logic [15:0] to_bcd(input logic [15:0] b);
      int v;
      v = (b > 16'd9999) ? 9999 : int'(b);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: cycles remaining until back in IDLE (0 = idle)
   int          m_left [2];
   logic [15:0] m_val  [2];
   logic [15:0] m_bcd  [2];
   logic        m_ovf  [2];
   logic        m_st;
   logic [15:0] m_b;

   // Reference model update on each rising edge
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_st = (k == 0) ? if0.start : 1'b1;
         m_b  = (k == 0) ? if0.bin   : if1.bin;
         if (!rst_n) begin
            m_left[k] = 0;
            m_bcd[k]  = 16'h0000;
            m_ovf[k]  = 1'b0;
         end else if (m_left[k] == 0) begin
            if (m_st) begin
               m_left[k] = 17;
               m_val[k]  = m_b;
            end
         end else begin
            m_left[k]--;
            if (m_left[k] == 1) begin
               m_bcd[k] = to_bcd(m_val[k]);
               m_ovf[k] = (m_val[k] > 16'd9999);
            end
         end
      end
   end

   // Cycle-by-cycle comparison of both instances against the reference
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy0", 32'(if0.busy), 32'(m_left[0] != 0));
         chk("done0", 32'(if0.done), 32'(m_left[0] == 1));
         chk("bcd0",  32'(if0.bcd),  32'(m_bcd[0]));
         chk("ovf0",  32'(if0.ovf),  32'(m_ovf[0]));
         chk("busy1", 32'(if1.busy), 32'(m_left[1] != 0));
         chk("done1", 32'(if1.done), 32'(m_left[1] == 1));
         chk("bcd1",  32'(if1.bcd),  32'(m_bcd[1]));
         chk("ovf1",  32'(if1.ovf),  32'(m_ovf[1]));
      end
   end

   // Operand sweep for the free-running instance
   initial begin
      int a_val;
      a_val     = 0;
      if1.start = 1'b0;
      if1.bin   = 16'd0;
      forever begin
         @(negedge clk);
         a_val = (a_val + 13) % 10000;
         if ($urandom_range(0, 15) == 0) if1.bin = 16'($urandom);
         else                            if1.bin = 16'(a_val);
      end
   end

   task automatic wait_idle();
      int w;
      w = 0;
      while (if0.busy && w < 40) begin
         @(negedge clk);
         w++;
      end
   endtask

   // Wait for done (bounded); returns cycles since accept and busy cycles
   task automatic wait_done(output int n, output int bc);
      n  = 1;
      bc = 0;
      forever begin
         if (if0.busy) bc++;
         if (if0.done || n >= 40) break;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic conv(input logic [15:0] v, input logic [15:0] eb, input logic eo);
      int n;
      int bc;
      wait_idle();
      if0.start = 1'b1;
      if0.bin   = v;
      @(negedge clk);
      if0.start = 1'b0;
      if0.bin   = 16'($urandom);
      wait_done(n, bc);
      chk("latency",     32'(n),        32'd17);
      chk("busy_cycles", 32'(bc),       32'd17);
      chk("bcd_lit",     32'(if0.bcd),  32'(eb));
      chk("ovf_lit",     32'(if0.ovf),  32'(eo));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bc;
      int d;
      checks    = 0;
      errors    = 0;
      chk_en    = 1'b0;
      rst_n     = 1'b0;
      if0.start = 1'b0;
      if0.bin   = 16'd0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy", 32'(if0.busy), 32'd0);
      chk("rst_done", 32'(if0.done), 32'd0);
      chk("rst_bcd",  32'(if0.bcd),  32'h0);
      chk("rst_ovf",  32'(if0.ovf),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      conv(16'd0,     16'h0000, 1'b0);
      conv(16'd1234,  16'h1234, 1'b0);
      conv(16'd9999,  16'h9999, 1'b0);
      conv(16'd7,     16'h0007, 1'b0);
      conv(16'd10000, 16'h9999, 1'b1);
      conv(16'd65535, 16'h9999, 1'b1);
      conv(16'd42,    16'h0042, 1'b0);

      // Start and operand change during a conversion are ignored
      wait_idle();
      if0.start = 1'b1;
      if0.bin   = 16'd500;
      @(negedge clk);
      if0.start = 1'b0;
      repeat (4) @(negedge clk);
      if0.bin   = 16'd8;
      if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      wait_done(n, bc);
      chk("mid_bcd", 32'(if0.bcd), 32'h0500);
      chk("mid_ovf", 32'(if0.ovf), 32'd0);
      d = 0;
      repeat (30) begin
         @(negedge clk);
         if (if0.done) d++;
      end
      chk("mid_no_second", 32'(d), 32'd0);

      // Reset in the middle of a conversion discards it
      wait_idle();
      if0.start = 1'b1;
      if0.bin   = 16'd4321;
      @(negedge clk);
      if0.start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      d = 0;
      repeat (20) begin
         if (if0.done) d++;
         @(negedge clk);
      end
      chk("rstmid_done", 32'(d),        32'd0);
      chk("rstmid_bcd",  32'(if0.bcd),  32'h0);
      chk("rstmid_busy", 32'(if0.busy), 32'd0);
      conv(16'd4321, 16'h4321, 1'b0);

      // Randomized traffic: pulses, held start, occasional resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ((c % 500) < 100) if0.start = 1'b1;
         else                 if0.start = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0) if0.bin = 16'($urandom);
         else                           if0.bin = 16'($urandom_range(0, 9999));
         rst_n = ($urandom_range(0, 399) != 0);
      end
      if0.start = 1'b0;
      rst_n     = 1'b1;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the four-digit seven-segment driver. It converts a 16-bit unsigned binary value into four packed BCD digits using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. The packed result drives the display driver's 16-bit data input with the driver in hex mode, so the driver no longer needs its divide/modulo path. Values above 9999 saturate to 9999 and raise an overflow flag.

## Interface

- `AUTO`, default 0: when 1, the block starts a new conversion automatically on every cycle it is in IDLE, ignoring `start`; when 0, conversions run only on `start`.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `start`  input  1  conversion request; sampled only in IDLE (`AUTO`=0).
- `bin`  input  16  unsigned binary value; sampled on the accepting edge only.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse when `bcd` and `ovf` update.
- `bcd`  output  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones; held between conversions.
- `ovf`  output  1  high when the last converted `bin` exceeded 9999; held with `bcd`.

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE: on an edge with `start`=1 (or always when `AUTO`=1), do the following, then go to SHIFT:
  - Load the clamped operand into the 16-bit binary shift register: `bin` if `bin` ≤ 9999, else 9999.
  - Capture `ovf_next` = (`bin` > 9999).
  - Clear the 16-bit BCD scratch register.
  - Clear the 5-bit iteration counter.
- SHIFT, once per cycle:
  - Correct each scratch nibble: if it is ≥ 5, add 3 (4-bit add, no carry between nibbles).
  - Shift {scratch, binary} left by 1, inserting 0 at the LSB.
  - Increment the counter.
  - After the 16th shift (counter reaches 16), go to DONE.
- DONE (one cycle): `bcd` ← scratch, `ovf` ← `ovf_next`, `done`=1. Next state is IDLE.
- Because of clamping, every scratch nibble stays in 0–9. No fifth digit is needed.
- `bcd`/`ovf` change only in DONE. Downstream sees stable digits during a conversion, so there is no display flicker.
- `start` asserted while not in IDLE is ignored. It is not queued.
- `bin` changes after the accepting edge have no effect on the conversion in progress.

## Timing

- Reset (`rst_n`=0 at a rising edge), taking effect regardless of state, including mid-SHIFT:
  - State becomes IDLE.
  - `busy`=0, `done`=0, `bcd`=16'h0000, `ovf`=0.
  - Counter and scratch are cleared.
- A conversion in progress at reset is discarded with no `done` pulse.
- Accepting edge E (IDLE, `start`=1): `busy`=1 from E to E+17. SHIFT spans edges E+1..E+16.
- Edge E+16 enters DONE: `done`=1 and the new `bcd`/`ovf` are visible during the cycle after E+16.
- Edge E+17 returns to IDLE: `busy`=0, `done`=0.
- Accept-to-result latency: 17 cycles. Minimum start-to-start spacing: 18 cycles. `AUTO`=1 throughput: one result per 18 cycles.
- `start` held high continuously with `AUTO`=0 behaves like `AUTO`=1.
- `start` on the same edge that leaves DONE is not accepted. It is accepted on the next edge, in IDLE.
- `busy` and `done` are registered outputs, with no combinational path from any input.

## Test plan

- Reset, then `bin`=0, pulse `start` → `done` at accept+17, `bcd`=16'h0000, `ovf`=0, `busy` high for exactly 17 cycles.
- `bin`=1234 → `bcd`=16'h1234, `ovf`=0. Then `bin`=9999 → 16'h9999, `ovf`=0. Then `bin`=7 → 16'h0007. `bcd` holds the previous value until each `done`.
- `bin`=10000 → `bcd`=16'h9999, `ovf`=1. Then `bin`=65535 → 16'h9999, `ovf`=1. Then `bin`=42 → 16'h0042, `ovf`=0.
- Start `bin`=500; at accept+5 change `bin` to 8 and pulse `start` → one `done` only, `bcd`=16'h0500. No second conversion begins.
- Start `bin`=4321; assert `rst_n`=0 at accept+8 for one cycle → no `done`, `bcd`=16'h0000, `busy`=0. A new start with `bin`=4321 → 16'h4321.
- `AUTO`=1 with `bin` sweeping 0..9999 → `done` every 18 cycles, and each `bcd` matches the decimal of the `bin` sampled at its accepting edge (self-checking scoreboard).
